pipe_ex_mem_stage: RTL
======================

# pipe_ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage pipeline. It consumes the ID/EX register outputs, resolves operand forwarding, and runs the ALU. It registers the result, store data and MEM/WB control into the EX/MEM boundary. An optional iterative multiply/divide unit stalls the front of the pipeline while it runs.

## Interface
Parameters: none.

- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- EXwreg, EXm2reg, EXwmem  in  1 each  control from ID/EX
- EXisStoreHazards  in  1  store data comes from the forwarded EX/MEM result
- EXselectAlua, EXselectAlub  in  2 each  operand source selects
- EXaluc  in  4  ALU operation
- EXwn  in  5  destination register
- EXqa, EXqb, EXimmeOrSa  in  32 each  register operands; immediate or shift amount
- wbdata  in  32  MEM/WB write-back value, used for forwarding
- MEMwreg, MEMm2reg, MEMwmem  out  1 each  registered control
- MEMwn  out  5  registered destination
- MEMalu  out  32  registered ALU result; also the internal forwarding source
- MEMstoreData  out  32  registered store data
- stall  out  1  combinational; freezes PC, IF/ID and ID/EX while high

## Operation
- Operand A by EXselectAlua:
  - 00: EXqa
  - 01: MEMalu
  - 10: wbdata
  - 11: {27'b0, EXimmeOrSa[4:0]}
- Operand B by EXselectAlub:
  - 00: EXqb
  - 01: MEMalu
  - 10: wbdata
  - 11: EXimmeOrSa
- Store data: MEMalu if EXisStoreHazards, else EXqb.
- EXaluc decode:
  - 0000 ADD, 0001 SUB (32-bit wrap, no overflow trap)
  - 0010 AND, 0011 OR, 0100 XOR, 1011 NOR
  - 0101 LUI: B<<16
  - 0110 SLL, 0111 SRL, 1000 SRA: shift B by A[4:0]
  - 1001 SLT (signed), 1010 SLTU: result 0 or 1
  - 1100 MUL: low 32 bits of A*B
  - 1101 DIVU: quotient; 1110 REMU: remainder
  - 1111: result 0
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE with aluc in 1100..1110: stall=1. At the clock edge, latch A, B and the op, clear the 5-bit counter, go to BUSY.
  - BUSY: stall=1. One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle. After 32 steps, go to DONE.
  - DONE: stall=0 and the latched result drives the ALU output. At the clock edge, EX/MEM captures it and the FSM goes to IDLE.
- While stall=1, EX/MEM loads a bubble: MEMwreg=MEMwmem=MEMm2reg=0, MEMwn=0, MEMalu and MEMstoreData hold.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.

## Timing
- Reset: all MEM* outputs 0, FSM IDLE, counter 0, stall 0. Reset takes effect immediately, including mid-operation; the in-flight op is discarded.
- Single-cycle ops: one clock from ID/EX valid to MEM* valid.
- MUL/DIVU/REMU:
  - stall high for 33 cycles (IDLE cycle + 32 BUSY cycles).
  - MEM* valid at the edge ending DONE, 34 edges after the op entered EX.
- Operands are sampled only in the IDLE cycle. Forwarding sources changing during BUSY have no effect.
- Back-to-back muldiv ops: the second op sees IDLE on the cycle after DONE and starts a new 33-cycle stall.
- MEMalu forwarding reflects the value registered at the previous edge, including holds during stall.

## Configuration
- MULDIV_EN defined: FSM, counter and multiply/divide datapath are compiled in as above.
- MULDIV_EN undefined: aluc 1100..1110 behave as 1111 (result 0, single cycle), stall is tied to 0, and no FSM exists.

## Test plan
- Reset mid-BUSY: clrn low at BUSY step 10 -> all MEM* outputs and stall are 0 immediately; the next ADD completes in 1 cycle.
- ADD with EXselectAlua=01, MEMalu=5, EXqb=7, EXselectAlub=00 -> MEMalu=12 after one edge; MEMwreg follows EXwreg.
- SRA with EXselectAlua=11, EXimmeOrSa=4, EXqb=0x80000000 -> MEMalu=0xF8000000. SLT with A=-1, B=1 -> 1; SLTU with the same operands -> 0.
- Store with EXisStoreHazards=1, MEMalu=0xDEADBEEF, EXqb=0 -> MEMstoreData=0xDEADBEEF and MEMwmem=1.
- MULDIV_EN, MUL 0x10000*0x10001 -> stall high for exactly 33 cycles with bubbles in EX/MEM, then MEMalu=0x00010000.
- MULDIV_EN, DIVU 100/7 -> 14 and REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.

Source files
------------

// File: rtl/pipe_ex_mem_stage.sv
// -----------------------------------------------------------------------------
// pipe_ex_mem_stage
//
// Execute stage plus the EX/MEM pipeline register of the 5-stage pipeline.
// Picks the ALU operands from the register file values, the EX/MEM result,
// the MEM/WB write-back value or the immediate. Runs the ALU and registers
// the result, the store data and the MEM/WB control into EX/MEM.
//
// Compile-time option:
//   MULDIV_EN - when defined, an iterative multiply/divide unit is built in.
//               It has a shift-add multiplier and a restoring divider, and it
//               does one step per cycle for 32 cycles. While it runs, it holds
//               stall high. When undefined, MUL/DIVU/REMU return 0 in a single
//               cycle and stall is tied low.
//
// Ports:
//   clk, clrn                      clock (rising edge), async active-low reset
//   EXwreg, EXm2reg, EXwmem        control from ID/EX
//   EXisStoreHazards               store data taken from forwarded MEMalu
//   EXselectAlua, EXselectAlub     operand source selects
//   EXaluc                         ALU operation
//   EXwn                           destination register
//   EXqa, EXqb, EXimmeOrSa         register operands, immediate / shift amount
//   wbdata                         MEM/WB write-back value (forwarding source)
//   MEMwreg, MEMm2reg, MEMwmem     registered control
//   MEMwn                          registered destination
//   MEMalu                         registered ALU result (forwarding source)
//   MEMstoreData                   registered store data
//   stall                          combinational; freezes PC, IF/ID and ID/EX
// -----------------------------------------------------------------------------
module pipe_ex_mem_stage (
    input  logic        clk,
    input  logic        clrn,
    input  logic        EXwreg,
    input  logic        EXm2reg,
    input  logic        EXwmem,
    input  logic        EXisStoreHazards,
    input  logic [1:0]  EXselectAlua,
    input  logic [1:0]  EXselectAlub,
    input  logic [3:0]  EXaluc,
    input  logic [4:0]  EXwn,
    input  logic [31:0] EXqa,
    input  logic [31:0] EXqb,
    input  logic [31:0] EXimmeOrSa,
    input  logic [31:0] wbdata,
    output logic        MEMwreg,
    output logic        MEMm2reg,
    output logic        MEMwmem,
    output logic [4:0]  MEMwn,
    output logic [31:0] MEMalu,
    output logic [31:0] MEMstoreData,
    output logic        stall
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
`ifdef MULDIV_EN
    localparam logic [3:0] ALU_MUL  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_REMU = 4'b1110;
`endif

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] store_data;
    logic [31:0] alu_comb;
    logic [31:0] alu_res;

    // Operand forwarding muxes. MEMalu is the registered value from the last
    // edge, so during a stall it forwards the held result.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_a = EXqa;
        case (EXselectAlua)
            2'b00:   alu_a = EXqa;
            2'b01:   alu_a = MEMalu;
            2'b10:   alu_a = wbdata;
            default: alu_a = {27'b0, EXimmeOrSa[4:0]};
        endcase
    end

    always_comb begin
        alu_b = EXqb;
        case (EXselectAlub)
            2'b00:   alu_b = EXqb;
            2'b01:   alu_b = MEMalu;
            2'b10:   alu_b = wbdata;
            default: alu_b = EXimmeOrSa;
        endcase
    end

    assign store_data = EXisStoreHazards ? MEMalu : EXqb;

    // Single-cycle ALU. The multiply/divide codes fall through to 0 here.
    // When the iterative unit is present, it supplies their result in DONE.
    always_comb begin
        alu_comb = 32'b0;
        case (EXaluc)
            ALU_ADD:  alu_comb = alu_a + alu_b;
            ALU_SUB:  alu_comb = alu_a - alu_b;
            ALU_AND:  alu_comb = alu_a & alu_b;
            ALU_OR:   alu_comb = alu_a | alu_b;
            ALU_XOR:  alu_comb = alu_a ^ alu_b;
            ALU_NOR:  alu_comb = ~(alu_a | alu_b);
            ALU_LUI:  alu_comb = {alu_b[15:0], 16'b0};
            ALU_SLL:  alu_comb = alu_b << alu_a[4:0];
            ALU_SRL:  alu_comb = alu_b >> alu_a[4:0];
            ALU_SRA:  alu_comb = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            ALU_SLT:  alu_comb = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_comb = {31'b0, alu_a < alu_b};
            default:  alu_comb = 32'b0;
        endcase
    end

`ifdef MULDIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    md_state_t   state;
    logic [4:0]  count;
    logic [3:0]  md_op;
    // Shared datapath registers:
    //   MUL : md_hi = product accumulator, md_lo = multiplier (shifts right),
    //         md_d = multiplicand (shifts left)
    //   DIV : md_hi = partial remainder, md_lo = dividend shifting out while
    //         quotient bits shift in, md_d = divisor
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic [31:0] md_d;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [32:0] rem_shift;
    logic        rem_fits;
    logic        is_muldiv;
    logic        md_start;

    assign is_muldiv = (EXaluc == ALU_MUL) || (EXaluc == ALU_DIVU) ||
                       (EXaluc == ALU_REMU);
    assign md_start  = (state == S_IDLE) && is_muldiv;

    // A restoring-divide step subtracts whenever the shifted remainder
    // reaches the divisor. With a zero divisor every step subtracts. This
    // gives an all-ones quotient and leaves the dividend as the remainder.
    always_comb begin
        step_hi   = md_hi;
        step_lo   = md_lo;
        rem_shift = {md_hi, md_lo[31]};
        rem_fits  = rem_shift >= {1'b0, md_d};
        if (md_op == ALU_MUL) begin
            step_hi = md_lo[0] ? md_hi + md_d : md_hi;
            step_lo = {1'b0, md_lo[31:1]};
        end else begin
            step_hi = rem_fits ? 32'(rem_shift - {1'b0, md_d}) : rem_shift[31:0];
            step_lo = {md_lo[30:0], rem_fits};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
            count <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_muldiv) begin
                        state <= S_BUSY;
                        count <= 5'd0;
                    end
                end
                S_BUSY: begin
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the datapath registers have no reset. They are always loaded in
    // the IDLE cycle before being read, so clearing them would only add reset
    // fan-out.
    always_ff @(posedge clk) begin
        if (md_start) begin
            md_op <= EXaluc;
            md_hi <= 32'b0;
            md_lo <= (EXaluc == ALU_MUL) ? alu_b : alu_a;
            md_d  <= (EXaluc == ALU_MUL) ? alu_a : alu_b;
        end else if (state == S_BUSY) begin
            md_hi <= step_hi;
            md_lo <= step_lo;
            if (md_op == ALU_MUL)
                md_d <= {md_d[30:0], 1'b0};
        end
    end

    assign alu_res = (state == S_DONE) ? ((md_op == ALU_DIVU) ? md_lo : md_hi)
                                       : alu_comb;
    // Gated by clrn so that stall drops while reset is asserted. Otherwise a
    // muldiv code still sitting in ID/EX would hold it high.
    assign stall   = clrn && (md_start || (state == S_BUSY));
`else
    assign alu_res = alu_comb;
    assign stall   = 1'b0;
`endif

    // EX/MEM register. A stall inserts a bubble: the control bits and the
    // destination are cleared, and the data fields hold.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            MEMwreg      <= 1'b0;
            MEMm2reg     <= 1'b0;
            MEMwmem      <= 1'b0;
            MEMwn        <= 5'd0;
            MEMalu       <= 32'b0;
            MEMstoreData <= 32'b0;
        end else if (stall) begin
            MEMwreg      <= 1'b0;
            MEMm2reg     <= 1'b0;
            MEMwmem      <= 1'b0;
            MEMwn        <= 5'd0;
        end else begin
            MEMwreg      <= EXwreg;
            MEMm2reg     <= EXm2reg;
            MEMwmem      <= EXwmem;
            MEMwn        <= EXwn;
            MEMalu       <= alu_res;
            MEMstoreData <= store_data;
        end
    end

endmodule
